// File: rtl/layer7_weight_seq_ctrl.sv
// Layer-7 weight memory sequencer: streams a weight load into the write port, then walks groups on the read port.
// Optional LAYER7_WCTRL_CHECKSUM_EN adds a running 16-bit sum of the words accepted in the most recent load.
module layer7_weight_seq_ctrl #(
    parameter int unsigned WEIGHT_NUM = 2000,
    parameter int unsigned AW         = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_start,
    input  logic [AW-1:0] load_count,
    input  logic [15:0]   in_weight_data,
    input  logic          in_weight_valid,
    output logic          in_weight_ready,
    output logic          write_weight_signal,
    output logic [AW-1:0] write_weight_addr,
    output logic [15:0]   write_weight_data,
    output logic          load_done,
    input  logic          compute_start,
    input  logic [AW-1:0] group_count,
    output logic          read_weight_signal,
    output logic [AW-1:0] read_weight_addr1,
    output logic [AW-1:0] read_weight_addr2,
    output logic          group_valid,
    input  logic          group_ready,
    output logic          compute_done,
    output logic          cfg_error,
    output logic [15:0]   load_checksum
);

    localparam int unsigned DW        = 16;
    localparam int unsigned CW        = AW + 4;
    localparam int unsigned BANK2_OFS = 25;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_LOADED = 2'd2,
        S_READ   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wr_cnt_q, wr_cnt_d;
    logic [AW-1:0] load_cnt_q, load_cnt_d;
    logic [AW-1:0] loaded_cnt_q, loaded_cnt_d;
    logic [AW-1:0] grp_q, grp_d;
    logic [AW-1:0] grp_cnt_q, grp_cnt_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0] wr_data_q, wr_data_d;
    logic          load_done_q, load_done_d;
    logic          compute_done_q, compute_done_d;
    logic          cfg_error_q, cfg_error_d;
`ifdef LAYER7_WCTRL_CHECKSUM_EN
    logic [DW-1:0] csum_q, csum_d;
`endif

    logic load_legal;
    logic group_legal;

    // Start legality: load must fit the memory; the last group's second bank must lie inside loaded data
    assign load_legal  = (load_count != '0) && (load_count <= AW'(WEIGHT_NUM));
    assign group_legal = (group_count != '0) &&
                         (((CW'(group_count) << 3) + CW'(BANK2_OFS)) <= CW'(loaded_cnt_q));

    // Next-state and registered-output logic
    always_comb begin
        state_d        = state_q;
        wr_cnt_d       = wr_cnt_q;
        load_cnt_d     = load_cnt_q;
        loaded_cnt_d   = loaded_cnt_q;
        grp_d          = grp_q;
        grp_cnt_d      = grp_cnt_q;
        wr_en_d        = 1'b0;
        wr_addr_d      = wr_addr_q;
        wr_data_d      = wr_data_q;
        load_done_d    = 1'b0;
        compute_done_d = 1'b0;
        cfg_error_d    = 1'b0;
`ifdef LAYER7_WCTRL_CHECKSUM_EN
        csum_d         = csum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (load_start) begin
                    if (load_legal) begin
                        state_d      = S_LOAD;
                        wr_cnt_d     = '0;
                        load_cnt_d   = load_count;
                        loaded_cnt_d = '0;
`ifdef LAYER7_WCTRL_CHECKSUM_EN
                        csum_d       = '0;
`endif
                    end else begin
                        cfg_error_d = 1'b1;
                    end
                end else if (compute_start) begin
                    cfg_error_d = 1'b1;
                end
            end
            S_LOAD: begin
                if (in_weight_valid) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = wr_cnt_q;
                    wr_data_d = in_weight_data;
`ifdef LAYER7_WCTRL_CHECKSUM_EN
                    csum_d    = csum_q + in_weight_data;
`endif
                    if (wr_cnt_q == load_cnt_q - AW'(1)) begin
                        state_d      = S_LOADED;
                        loaded_cnt_d = load_cnt_q;
                        load_done_d  = 1'b1;
                        wr_cnt_d     = '0;
                    end else begin
                        wr_cnt_d = wr_cnt_q + AW'(1);
                    end
                end
            end
            S_LOADED: begin
                // Reload takes priority over a simultaneous compute request
                if (load_start) begin
                    if (load_legal) begin
                        state_d      = S_LOAD;
                        wr_cnt_d     = '0;
                        load_cnt_d   = load_count;
                        loaded_cnt_d = '0;
`ifdef LAYER7_WCTRL_CHECKSUM_EN
                        csum_d       = '0;
`endif
                    end else begin
                        cfg_error_d = 1'b1;
                    end
                end else if (compute_start) begin
                    if (group_legal) begin
                        state_d   = S_READ;
                        grp_d     = '0;
                        grp_cnt_d = group_count;
                    end else begin
                        cfg_error_d = 1'b1;
                    end
                end
            end
            S_READ: begin
                if (group_ready) begin
                    if (grp_q == grp_cnt_q - AW'(1)) begin
                        state_d        = S_LOADED;
                        compute_done_d = 1'b1;
                        grp_d          = '0;
                    end else begin
                        grp_d = grp_q + AW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            wr_cnt_q       <= '0;
            load_cnt_q     <= '0;
            loaded_cnt_q   <= '0;
            grp_q          <= '0;
            grp_cnt_q      <= '0;
            wr_en_q        <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            load_done_q    <= 1'b0;
            compute_done_q <= 1'b0;
            cfg_error_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_cnt_q       <= wr_cnt_d;
            load_cnt_q     <= load_cnt_d;
            loaded_cnt_q   <= loaded_cnt_d;
            grp_q          <= grp_d;
            grp_cnt_q      <= grp_cnt_d;
            wr_en_q        <= wr_en_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
            load_done_q    <= load_done_d;
            compute_done_q <= compute_done_d;
            cfg_error_q    <= cfg_error_d;
        end
    end

`ifdef LAYER7_WCTRL_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end
    assign load_checksum = csum_q;
`else
    assign load_checksum = 16'd0;
`endif

    assign in_weight_ready     = (state_q == S_LOAD);
    assign read_weight_signal  = (state_q == S_READ);
    assign group_valid         = (state_q == S_READ);
    assign write_weight_signal = wr_en_q;
    assign write_weight_addr   = wr_addr_q;
    assign write_weight_data   = wr_data_q;
    assign load_done           = load_done_q;
    assign read_weight_addr1   = grp_q;
    assign read_weight_addr2   = grp_q;
    assign compute_done        = compute_done_q;
    assign cfg_error           = cfg_error_q;

endmodule

// File: tb/tb_layer7_weight_seq_ctrl.sv
// Self-checking bench for layer7_weight_seq_ctrl: randomized loads/group walks against a transaction-level model.
module tb_layer7_weight_seq_ctrl;

    localparam int unsigned AW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          load_start = 1'b0;
    logic [AW-1:0] load_count = '0;
    logic [15:0]   in_weight_data = '0;
    logic          in_weight_valid = 1'b0;
    logic          in_weight_ready;
    logic          write_weight_signal;
    logic [AW-1:0] write_weight_addr;
    logic [15:0]   write_weight_data;
    logic          load_done;
    logic          compute_start = 1'b0;
    logic [AW-1:0] group_count = '0;
    logic          read_weight_signal;
    logic [AW-1:0] read_weight_addr1;
    logic [AW-1:0] read_weight_addr2;
    logic          group_valid;
    logic          group_ready = 1'b0;
    logic          compute_done;
    logic          cfg_error;
    logic [15:0]   load_checksum;

    int n_checks = 0;
    int n_fail   = 0;
    int loaded   = 0;

    layer7_weight_seq_ctrl #(.WEIGHT_NUM(2000), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .load_start(load_start), .load_count(load_count),
        .in_weight_data(in_weight_data), .in_weight_valid(in_weight_valid),
        .in_weight_ready(in_weight_ready),
        .write_weight_signal(write_weight_signal), .write_weight_addr(write_weight_addr),
        .write_weight_data(write_weight_data), .load_done(load_done),
        .compute_start(compute_start), .group_count(group_count),
        .read_weight_signal(read_weight_signal),
        .read_weight_addr1(read_weight_addr1), .read_weight_addr2(read_weight_addr2),
        .group_valid(group_valid), .group_ready(group_ready),
        .compute_done(compute_done), .cfg_error(cfg_error),
        .load_checksum(load_checksum)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] csum_exp(input logic [15:0] s);
`ifdef LAYER7_WCTRL_CHECKSUM_EN
        return s;
`else
        return 16'd0;
`endif
    endfunction

    // Rejected load request: one cfg_error pulse, no load entered
    task automatic bad_load(input int n);
        load_start = 1'b1;
        load_count = AW'(n);
        step();
        load_start = 1'b0;
        check("bad_load_cfg_error", 32'(cfg_error), 1);
        check("bad_load_no_ready", 32'(in_weight_ready), 0);
        step();
        check("bad_load_cfg_pulse", 32'(cfg_error), 0);
    endtask

    // gap: 0 back-to-back, 1 every other cycle, 2 random; seq: words are 1,2,3,...
    task automatic do_load(input int n, input int gap, input bit seq, input bit with_compute);
        logic [15:0] sum;
        logic [15:0] d;
        logic        beat;
        int          acc;
        int          cyc;
        load_start    = 1'b1;
        load_count    = AW'(n);
        compute_start = with_compute;
        group_count   = AW'(1);
        step();
        load_start    = 1'b0;
        compute_start = 1'b0;
        check("load_entry_ready", 32'(in_weight_ready), 1);
        check("load_entry_csum", 32'(load_checksum), 0);
        check("load_entry_cfg", 32'(cfg_error), 0);
        load_count = AW'($urandom_range(1, 2000));
        sum = '0;
        acc = 0;
        cyc = 0;
        while (acc < n && cyc < 6000) begin
            case (gap)
                0:       beat = 1'b1;
                1:       beat = (cyc % 2 == 0);
                default: beat = 1'($urandom_range(0, 1));
            endcase
            d = seq ? 16'(acc + 1) : 16'($urandom);
            in_weight_valid = beat;
            in_weight_data  = d;
            check("load_ready", 32'(in_weight_ready), 1);
            step();
            cyc++;
            check("wr_en", 32'(write_weight_signal), 32'(beat));
            if (beat) begin
                check("wr_addr", 32'(write_weight_addr), 32'(acc));
                check("wr_data", 32'(write_weight_data), 32'(d));
                check("load_done", 32'(load_done), 32'(acc == n - 1));
                sum = sum + d;
                acc++;
            end else begin
                check("load_done_gap", 32'(load_done), 0);
            end
        end
        if (acc < n) check("load_timeout", 32'(acc), 32'(n));
        in_weight_valid = 1'b0;
        check("load_csum", 32'(load_checksum), 32'(csum_exp(sum)));
        check("ready_after_load", 32'(in_weight_ready), 0);
        in_weight_valid = 1'b1;
        step();
        in_weight_valid = 1'b0;
        check("no_extra_write", 32'(write_weight_signal), 0);
        check("no_extra_done", 32'(load_done), 0);
        check("csum_hold", 32'(load_checksum), 32'(csum_exp(sum)));
        loaded = n;
    endtask

    // Group walk; legality judged from the loaded word count
    task automatic do_read(input int g, input bit rdy_always);
        bit legal;
        bit r;
        int k;
        int cyc;
        group_count   = AW'(g);
        compute_start = 1'b1;
        step();
        compute_start = 1'b0;
        legal = (g != 0) && (g * 8 + 25 <= loaded);
        if (!legal) begin
            check("read_cfg_error", 32'(cfg_error), 1);
            check("read_rej_valid", 32'(group_valid), 0);
            check("read_rej_ready", 32'(in_weight_ready), 0);
            step();
            check("read_cfg_pulse", 32'(cfg_error), 0);
            return;
        end
        check("read_start_cfg", 32'(cfg_error), 0);
        group_count = AW'($urandom_range(0, 300));
        load_start  = 1'b1;
        k = 0;
        cyc = 0;
        while (k < g && cyc < 3000) begin
            check("grp_valid", 32'(group_valid), 1);
            check("rd_en", 32'(read_weight_signal), 1);
            check("rd_addr1", 32'(read_weight_addr1), 32'(k));
            check("rd_addr2", 32'(read_weight_addr2), 32'(k));
            r = rdy_always ? 1'b1 : 1'($urandom_range(0, 1));
            group_ready = r;
            step();
            load_start = 1'b0;
            cyc++;
            if (r) k++;
            check("compute_done", 32'(compute_done), 32'(k == g));
        end
        if (k < g) check("read_timeout", 32'(k), 32'(g));
        group_ready = 1'b0;
        check("read_end_valid", 32'(group_valid), 0);
        check("read_end_rd", 32'(read_weight_signal), 0);
        check("read_end_addr", 32'(read_weight_addr1), 0);
        step();
        check("compute_done_pulse", 32'(compute_done), 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(in_weight_ready), 0);
        check("rst_wr_en", 32'(write_weight_signal), 0);
        check("rst_wr_addr", 32'(write_weight_addr), 0);
        check("rst_wr_data", 32'(write_weight_data), 0);
        check("rst_load_done", 32'(load_done), 0);
        check("rst_rd_en", 32'(read_weight_signal), 0);
        check("rst_addr1", 32'(read_weight_addr1), 0);
        check("rst_grp_valid", 32'(group_valid), 0);
        check("rst_compute_done", 32'(compute_done), 0);
        check("rst_cfg_error", 32'(cfg_error), 0);
        check("rst_csum", 32'(load_checksum), 0);
        rst = 1'b1;
        step();

        do_read(1, 1'b1);
        bad_load(0);
        bad_load(2001);

        do_load(4, 0, 1'b1, 1'b0);
        do_load(3, 1, 1'b0, 1'b0);
        do_load(40, 2, 1'b0, 1'b0);
        do_read(1, 1'b0);
        do_read(2, 1'b1);
        do_read(0, 1'b1);
        bad_load(2001);
        do_read(1, 1'b1);

        // Reset in the middle of a load after five accepted words
        load_start = 1'b1;
        load_count = AW'(10);
        step();
        load_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_weight_valid = 1'b1;
            in_weight_data  = 16'($urandom);
            step();
        end
        in_weight_valid = 1'b0;
        check("pre_rst_wr_en", 32'(write_weight_signal), 1);
        check("pre_rst_wr_addr", 32'(write_weight_addr), 4);
        #1 rst = 1'b0;
        #1;
        check("mid_rst_wr_en", 32'(write_weight_signal), 0);
        check("mid_rst_ready", 32'(in_weight_ready), 0);
        check("mid_rst_wr_addr", 32'(write_weight_addr), 0);
        check("mid_rst_csum", 32'(load_checksum), 0);
        #2 rst = 1'b1;
        loaded = 0;
        step();
        do_read(1, 1'b1);

        do_load(40, 2, 1'b0, 1'b0);
        do_load(50, 2, 1'b0, 1'b1);
        do_read(3, 1'b0);

        do_load(2000, 0, 1'b0, 1'b0);
        do_read(3, 1'b1);
        do_read(250, 1'b1);
        do_read(247, 1'b1);
        do_read(246, 1'b0);
        do_load(2000, 2, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
